// File: rtl/blinky_seq.sv
// Five-LED pattern sequencer: prescaler tick drives a LAMP -> RUN controller.
// Define BLINKY_SEQ_GRAY_EN to show a 4-bit Gray count on led1..led4 instead of a one-hot rotation.
module blinky_seq #(
    parameter int DIV = 900000
) (
    input  logic io_0_8_1,
    input  logic io_0_9_1,
    input  logic io_0_10_1,
    output logic io_13_12_1,
    output logic io_13_12_0,
    output logic io_13_11_1,
    output logic io_13_11_0,
    output logic io_13_9_1
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    typedef enum logic {
        LAMP,
        RUN
    } state_t;

    logic clk;
    logic rst_n;
    logic hold;

    assign clk   = io_0_8_1;
    assign rst_n = io_0_9_1;
    assign hold  = io_0_10_1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;
    state_t        state_q, state_d;
    logic [3:0]    pat_q, pat_d;
    logic          hb_q, hb_d;

`ifdef BLINKY_SEQ_GRAY_EN
    logic [3:0]    k_q, k_d;
`endif

    // Hold freezes the count, so a suppressed tick simply fires on the next free edge.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!hold) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        hb_d    = hb_q;
`ifdef BLINKY_SEQ_GRAY_EN
        k_d     = k_q;
`endif
        if (tick) begin
            case (state_q)
                LAMP: begin
                    state_d = RUN;
                    hb_d    = 1'b0;
`ifdef BLINKY_SEQ_GRAY_EN
                    k_d     = 4'd0;
                    pat_d   = 4'b0000;
`else
                    pat_d   = 4'b1000;
`endif
                end
                RUN: begin
                    hb_d = ~hb_q;
`ifdef BLINKY_SEQ_GRAY_EN
                    k_d   = k_q + 4'd1;
                    pat_d = k_d ^ (k_d >> 1);
`else
                    // pat[3] is led1, so shifting right moves the lit LED from led1 toward led4.
                    pat_d = {pat_q[0], pat_q[3:1]};
`endif
                end
                default: state_d = LAMP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            state_q <= LAMP;
            pat_q   <= 4'b1111;
            hb_q    <= 1'b1;
`ifdef BLINKY_SEQ_GRAY_EN
            k_q     <= 4'd0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            pat_q   <= pat_d;
            hb_q    <= hb_d;
`ifdef BLINKY_SEQ_GRAY_EN
            k_q     <= k_d;
`endif
        end
    end

    assign io_13_12_1 = pat_q[3];
    assign io_13_12_0 = pat_q[2];
    assign io_13_11_1 = pat_q[1];
    assign io_13_11_0 = pat_q[0];
    assign io_13_9_1  = hb_q;

endmodule

// File: tb/tb_blinky_seq.sv
// Randomised self-checking bench for blinky_seq with DIV=4.
// The reference counts unheld edges since reset and derives the LED pattern from the tick number.
module tb_blinky_seq;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hold = 1'b0;
    logic led1, led2, led3, led4, led5;

    int total = 0;
    int bad = 0;
    int active_edges = 0;

    always #5 clk = ~clk;

    blinky_seq #(.DIV(DIV)) dut (
        .io_0_8_1   (clk),
        .io_0_9_1   (rst_n),
        .io_0_10_1  (hold),
        .io_13_12_1 (led1),
        .io_13_12_0 (led2),
        .io_13_11_1 (led3),
        .io_13_11_0 (led4),
        .io_13_9_1  (led5)
    );

    function automatic logic [4:0] get_leds();
        return {led1, led2, led3, led4, led5};
    endfunction

    // Tick n>0 shows pattern number n-1; the heartbeat starts at 0 on the first tick.
    function automatic logic [4:0] model_leds(input int ticks);
        int idx;
        logic [3:0] g;
        logic [3:0] pat;
        if (ticks == 0) return 5'b11111;
        idx = ticks - 1;
`ifdef BLINKY_SEQ_GRAY_EN
        g   = 4'(idx % 16);
        pat = g ^ (g >> 1);
`else
        g   = 4'b1000;
        pat = g >> (idx % 4);
`endif
        return {pat, 1'(idx % 2)};
    endfunction

    function automatic logic [4:0] expected_now();
        return model_leds(active_edges / DIV);
    endfunction

    task automatic apply_stimulus(input logic h);
        hold = h;
        @(posedge clk);
        if (rst_n && !h) active_edges++;
        #1;
    endtask

    // Called one time unit after a rising edge; reset is applied and released between edges.
    task automatic do_reset();
        hold = 1'b0;
        #2 rst_n = 1'b0;
        active_edges = 0;
        #3 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        total++;
        if (get_leds() !== 5'b11111) begin
            bad++;
            $display("[TB] FAIL reset_held: got %b expected %b", get_leds(), 5'b11111);
        end
        do_reset();
        total++;
        if (get_leds() !== 5'b11111) begin
            bad++;
            $display("[TB] FAIL reset_released: got %b expected %b", get_leds(), 5'b11111);
        end
    endtask

    task automatic test_basic();
        logic [4:0] want;
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            apply_stimulus(1'b0);
            total++;
            if (get_leds() !== expected_now()) begin
                bad++;
                $display("[TB] FAIL basic_e%0d: got %b expected %b", e, get_leds(), expected_now());
            end
            if (e % 4 == 0) begin
`ifdef BLINKY_SEQ_GRAY_EN
                want = (e == 4) ? 5'b00000 : (e == 8) ? 5'b00011 : 5'b00110;
`else
                want = (e == 4) ? 5'b10000 : (e == 8) ? 5'b01001 : 5'b00100;
`endif
                total++;
                if (get_leds() !== want) begin
                    bad++;
                    $display("[TB] FAIL basic_const_e%0d: got %b expected %b", e, get_leds(), want);
                end
            end
        end
    endtask

    task automatic test_long_run();
        logic [3:0] prev_pat;
        logic [3:0] pat;
        prev_pat = 4'b0000;
        do_reset();
        for (int e = 1; e <= 80; e++) begin
            apply_stimulus(1'b0);
            total++;
            if (get_leds() !== expected_now()) begin
                bad++;
                $display("[TB] FAIL run_e%0d: got %b expected %b", e, get_leds(), expected_now());
            end
            if (e % DIV == 0) begin
                pat = get_leds() >> 1;
`ifdef BLINKY_SEQ_GRAY_EN
                if (e > DIV) begin
                    total++;
                    if ($countones(pat ^ prev_pat) != 1) begin
                        bad++;
                        $display("[TB] FAIL gray_step_e%0d: got %b after %b expected one bit change", e, pat, prev_pat);
                    end
                end
`else
                total++;
                if (!$onehot(pat)) begin
                    bad++;
                    $display("[TB] FAIL onehot_e%0d: got %b expected one-hot", e, pat);
                end
`endif
                prev_pat = pat;
            end
        end
    endtask

    task automatic test_hold();
        logic h;
        logic [4:0] want;
        do_reset();
        for (int e = 1; e <= 16; e++) begin
            h = (e >= 3 && e <= 10);
            apply_stimulus(h);
            total++;
            if (get_leds() !== expected_now()) begin
                bad++;
                $display("[TB] FAIL hold_e%0d: got %b expected %b", e, get_leds(), expected_now());
            end
            if (e <= 11) begin
                total++;
                if (get_leds() !== 5'b11111) begin
                    bad++;
                    $display("[TB] FAIL hold_static_e%0d: got %b expected %b", e, get_leds(), 5'b11111);
                end
            end
            if (e == 12) begin
`ifdef BLINKY_SEQ_GRAY_EN
                want = 5'b00000;
`else
                want = 5'b10000;
`endif
                total++;
                if (get_leds() !== want) begin
                    bad++;
                    $display("[TB] FAIL hold_first_tick: got %b expected %b", get_leds(), want);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int e = 1; e <= 9; e++) apply_stimulus(1'b0);
        total++;
        if (get_leds() !== expected_now()) begin
            bad++;
            $display("[TB] FAIL async_pre: got %b expected %b", get_leds(), expected_now());
        end
        #3 rst_n = 1'b0;
        active_edges = 0;
        #1;
        total++;
        if (get_leds() !== 5'b11111) begin
            bad++;
            $display("[TB] FAIL async_immediate: got %b expected %b", get_leds(), 5'b11111);
        end
        #2 rst_n = 1'b1;
        for (int e = 1; e <= DIV + 1; e++) begin
            apply_stimulus(1'b0);
            total++;
            if (get_leds() !== expected_now()) begin
                bad++;
                $display("[TB] FAIL async_after_e%0d: got %b expected %b", e, get_leds(), expected_now());
            end
        end
    endtask

    task automatic test_lamp_hold();
        do_reset();
        apply_stimulus(1'b0);
        apply_stimulus(1'b0);
        for (int c = 0; c < 100; c++) begin
            apply_stimulus(1'b1);
            total++;
            if (get_leds() !== 5'b11111) begin
                bad++;
                $display("[TB] FAIL lamp_hold_c%0d: got %b expected %b", c, get_leds(), 5'b11111);
            end
        end
        // Two retained counts mean the tick arrives on the second released edge, not the fourth.
        for (int e = 1; e <= 2; e++) begin
            apply_stimulus(1'b0);
            total++;
            if (get_leds() !== expected_now()) begin
                bad++;
                $display("[TB] FAIL lamp_release_e%0d: got %b expected %b", e, get_leds(), expected_now());
            end
        end
    endtask

    task automatic test_random();
        logic h;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            h = ($urandom_range(0, 3) == 0);
            apply_stimulus(h);
            total++;
            if (get_leds() !== expected_now()) begin
                bad++;
                $display("[TB] FAIL random_i%0d: got %b expected %b", i, get_leds(), expected_now());
            end
            if ($urandom_range(0, 149) == 0) begin
                #3 rst_n = 1'b0;
                active_edges = 0;
                #1;
                total++;
                if (get_leds() !== 5'b11111) begin
                    bad++;
                    $display("[TB] FAIL random_reset_i%0d: got %b expected %b", i, get_leds(), 5'b11111);
                end
                #2 rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_long_run();
        test_hold();
        test_async_reset();
        test_lamp_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
